// File: rtl/ram_burst_pkg.sv
// Shared constants and types for the 64x8 RAM burst initiator.
package ram_burst_pkg;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned AW     = 6;
  localparam int unsigned DW     = 8;
  localparam int unsigned SKID   = 2;
  localparam int unsigned MEM_AW = 7;
  localparam int unsigned CNT_W  = $clog2(SKID + 1);
  localparam int unsigned PTR_W  = (SKID > 1) ? $clog2(SKID) : 1;
  localparam int unsigned OCC_W  = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } rd_beat_t;

endpackage

// File: rtl/ram_rsp_skid.sv
// Small FIFO holding read-return beats so the RAM can be read ahead of client backpressure.
module ram_rsp_skid
  import ram_burst_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  rd_beat_t         push_beat_i,
  input  logic             pop_i,
  output rd_beat_t         head_o,
  output logic [CNT_W-1:0] count_o
);

  rd_beat_t         mem_q [SKID];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == SKID - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SKID; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_beat_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the 64x8 single-port RAM: command port, write-beat stream,
// read-beat stream with backpressure absorbed by a credit-limited return buffer.
module ram_burst_master
  import ram_burst_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [AW-1:0]     cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DW-1:0]     wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DW-1:0]     rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              mem_write_en,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_data_in,
  input  logic [DW-1:0]     mem_data_out
);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             inflight_q, inflight_d;
  logic             last_q, last_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_data_q, mem_data_d;
  logic             mem_we_c;

  rd_beat_t         skid_head;
  rd_beat_t         push_beat;
  logic [CNT_W-1:0] skid_count;
  logic             pop_c;
  logic [OCC_W-1:0] occ_c;
  logic             can_issue_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      last_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      last_q     <= last_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Buffer slots already claimed, with a beat leaving this cycle handed back.
  assign pop_c       = rd_valid && rd_ready;
  assign occ_c       = OCC_W'(skid_count) + OCC_W'(inflight_q) - OCC_W'(pop_c);
  assign can_issue_c = (occ_c < OCC_W'(SKID));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    inflight_d = 1'b0;
    last_d     = last_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          mem_we_c   = 1'b1;
          mem_addr_d = addr_q;
          mem_data_d = wr_data;
          addr_d     = addr_q + AW'(1);
          cnt_d      = cnt_q - AW'(1);
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      READ: begin
        if (can_issue_c) begin
          mem_addr_d = addr_q;
          addr_d     = addr_q + AW'(1);
          cnt_d      = cnt_q - AW'(1);
          inflight_d = 1'b1;
          last_d     = (cnt_q == '0);
          if (cnt_q == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_beat = '{last: last_q, data: mem_data_out};

  ram_rsp_skid u_skid (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_beat_i (push_beat),
    .pop_i       (pop_c),
    .head_o      (skid_head),
    .count_o     (skid_count)
  );

  assign rd_valid     = (skid_count != '0);
  assign rd_data      = rd_valid ? skid_head.data : '0;
  assign rd_last      = rd_valid && skid_head.last;
  assign wr_ready     = (state_q == WRITE);
  // A read still in flight in IDLE must land before another burst may start.
  assign cmd_ready    = (state_q == IDLE) && (skid_count == '0) && !inflight_q;
  assign busy         = (state_q != IDLE) || (skid_count != '0) || inflight_q;
  assign mem_write_en = mem_we_c;
  assign mem_addr     = {1'b0, mem_addr_d};
  assign mem_data_in  = mem_data_d;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 64x8 RAM attached.
module tb_ram_burst_master;

  logic       clk;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready, rd_last;
  logic [7:0] rd_data;
  logic       busy;
  logic       mem_write_en;
  logic [6:0] mem_addr;
  logic [7:0] mem_data_in, mem_data_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0]  ram [64];
  logic [7:0]  pat [64];
  logic [13:0] wr_log [$];
  logic [8:0]  rd_log [$];
  int          rd_cyc [$];

  bit          stall_q = 0;
  logic [7:0]  stall_data;
  logic        stall_last;

  ram_burst_master dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .busy         (busy),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: synchronous write, read data one clock after the address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_en) ram[mem_addr[5:0]] <= mem_data_in;
    mem_data_out <= ram[mem_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observe handshakes and protocol properties between clock edges.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cmd_ready_vs_busy", 32'(cmd_ready), 32'(!busy));
      if (mem_write_en) begin
        chk("we_on_handshake", 32'(wr_valid && wr_ready), 32'd1);
        chk("mem_addr_bit6", 32'(mem_addr[6]), 32'd0);
        wr_log.push_back({mem_addr[5:0], mem_data_in});
      end
      if (stall_q) begin
        chk("stall_valid", 32'(rd_valid), 32'd1);
        chk("stall_data", 32'(rd_data), 32'(stall_data));
        chk("stall_last", 32'(rd_last), 32'(stall_last));
      end
      if (rd_valid && rd_ready) begin
        rd_log.push_back({rd_last, rd_data});
        rd_cyc.push_back(cyc);
      end
      stall_q    = rd_valid && !rd_ready;
      stall_data = rd_data;
      stall_last = rd_last;
    end else begin
      stall_q = 0;
    end
  end

  task automatic check_reset_vals();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_we", 32'(mem_write_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_data_in), 32'd0);
  endtask

  task automatic do_cmd(input logic wr, input int addr, input int len);
    bit hs = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = 6'(addr);
    cmd_len   = 6'(len);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        hs = 1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!hs) chk("cmd_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_beat(input logic [7:0] d);
    bit hs = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        hs = 1;
        break;
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (!hs) chk("wr_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!idle) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rd(input int n, input bit toggle);
    rd_ready = 1'b1;
    for (int i = 0; i < 400 && rd_log.size() < n; i++) begin
      @(posedge clk); #1;
      if (toggle) rd_ready = ~rd_ready;
    end
    rd_ready = 1'b0;
    chk("rd_count", 32'(rd_log.size()), 32'(n));
  endtask

  task automatic write_burst(input int addr, input int n, input bit gaps);
    logic [13:0] e;
    wr_log.delete();
    do_cmd(1'b1, addr, n - 1);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        repeat (2) begin
          @(posedge clk); #1;
        end
      end
      send_beat(pat[i]);
    end
    wait_idle();
    chk("wr_count", 32'(wr_log.size()), 32'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      e = wr_log[i];
      chk("wr_addr", 32'(e[13:8]), 32'((addr + i) % 64));
      chk("wr_data", 32'(e[7:0]), 32'(pat[i]));
    end
  endtask

  task automatic read_burst(input int addr, input int n, input bit toggle, input bit rate);
    logic [8:0] e;
    rd_log.delete();
    rd_cyc.delete();
    rd_ready = 1'b1;
    do_cmd(1'b0, addr, n - 1);
    wait_rd(n, toggle);
    wait_idle();
    for (int i = 0; i < n && i < rd_log.size(); i++) begin
      e = rd_log[i];
      chk("rd_data", 32'(e[7:0]), 32'(pat[i]));
      chk("rd_last", 32'(e[8]), 32'(i == n - 1));
      if (rate && i > 0) chk("rd_rate", 32'(rd_cyc[i] - rd_cyc[i-1]), 32'd1);
    end
  endtask

  initial begin
    logic [8:0] e;
    bit hs;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: basic write then full-rate read
    for (int i = 0; i < 4; i++) pat[i] = 8'hA0 + 8'(i);
    write_burst(5, 4, 0);
    read_burst(5, 4, 0, 1);

    // 2: address wrap 62,63,0,1
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    write_burst(62, 4, 0);
    read_burst(62, 4, 0, 1);

    // 3: read with rd_ready toggling
    for (int i = 0; i < 8; i++) pat[i] = 8'h30 + 8'(i);
    write_burst(10, 8, 0);
    read_burst(10, 8, 1, 0);

    // 4: write with wr_valid gaps
    for (int i = 0; i < 5; i++) pat[i] = 8'hC0 + 8'(i);
    write_burst(20, 5, 1);
    read_burst(20, 5, 0, 1);

    // 5: reset during a read burst
    for (int i = 0; i < 8; i++) pat[i] = 8'h50 + 8'(i);
    write_burst(40, 8, 0);
    rd_log.delete();
    rd_ready = 1'b1;
    do_cmd(1'b0, 40, 7);
    for (int i = 0; i < 100 && rd_log.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_beats", 32'(rd_log.size()), 32'd2);
    reset    = 1'b1;
    rd_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0;
    read_burst(40, 8, 0, 1);

    // 6: cmd_valid held across a burst, single-beat read
    pat[0] = 8'h61; pat[1] = 8'h62; pat[2] = 8'h63;
    wr_log.delete();
    rd_log.delete();
    do_cmd(1'b1, 30, 2);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 6'd30;
    cmd_len   = 6'd0;
    @(negedge clk);
    chk("cmd_ready_in_burst", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_beat(pat[i]);
    hs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        hs = 1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("held_cmd_accepted", 32'(hs), 32'd1);
    chk("held_wr_count", 32'(wr_log.size()), 32'd3);
    wait_rd(1, 0);
    wait_idle();
    if (rd_log.size() > 0) begin
      e = rd_log[0];
      chk("single_data", 32'(e[7:0]), 32'h61);
      chk("single_last", 32'(e[8]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
